// File: rtl/out_sched_pkg.sv
// out_sched_pkg: shared definitions for the M_AXIS output scheduler.
//   - IDLE/STREAM state encoding and the FSM state enum built on it.
//   - Default downstream credit count and packet-length field width.
package out_sched_pkg;

  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;

  typedef enum logic {
    StIdle   = IDLE,
    StStream = STREAM
  } sched_state_e;

  // A 4-deep FIFO with 2-bit pointers can hold only 3 entries (full aliases empty).
  localparam int unsigned DefaultCredits  = 3;
  localparam int unsigned DefaultLenWidth = 16;

endpackage

// File: rtl/out_credit_counter.sv
// out_credit_counter: saturating up/down counter of free downstream FIFO entries.
//   clk_i      clock
//   rst_ni     synchronous active-low reset, reloads the counter to CREDITS
//   take_i     one entry consumed (beat written to the FIFO)
//   ret_i      one entry drained from the FIFO
//   nonzero_o  at least one credit available
module out_credit_counter
  import out_sched_pkg::*;
#(
  parameter int unsigned CREDITS    = DefaultCredits,
  parameter int unsigned CRED_WIDTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic take_i,
  input  logic ret_i,
  output logic nonzero_o
);

  localparam logic [CRED_WIDTH-1:0] MaxCredits = CRED_WIDTH'(CREDITS);

  logic [CRED_WIDTH-1:0] cnt_q, cnt_d;

  // Take and return in the same cycle cancel out; a return at full is spurious and dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (take_i && !ret_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CRED_WIDTH'(1);
    end else if (ret_i && !take_i && (cnt_q != MaxCredits)) begin
      cnt_d = cnt_q + CRED_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= MaxCredits;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/axis_out_scheduler.sv
// axis_out_scheduler: packet-atomic round-robin arbiter between two result producers feeding
// the output FIFO / M_AXIS path. Generates TLAST from a per-packet beat count and never
// overruns the downstream FIFO, tracked by a credit counter.
//   M_AXIS_ACLK / M_AXIS_ARESETN  clock, synchronous active-low reset
//   cfg_len0 / cfg_len1           packet length minus 1 per requester, sampled at grant
//   reqN_valid / reqN_data        requester beat; reqN_ready accepts it
//   credit_ret                    one pulse per entry drained from the downstream FIFO
//   TDATA_out/TVALID_out/TLAST_out  registered beat to the FIFO (1-cycle latency)
//   busy                          packet in progress
//   grant_id                      current/last granted requester
//   pkt_cnt0 / pkt_cnt1           completed-packet counters, only with OUT_SCHED_PKT_CNT_EN
module axis_out_scheduler
  import out_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = DefaultLenWidth,
  parameter int unsigned CREDITS    = DefaultCredits,
  parameter int unsigned CRED_WIDTH = 2
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic [LEN_WIDTH-1:0]  cfg_len0,
  input  logic [LEN_WIDTH-1:0]  cfg_len1,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  credit_ret,
  output logic [DATA_WIDTH-1:0] TDATA_out,
  output logic                  TVALID_out,
  output logic                  TLAST_out,
`ifdef OUT_SCHED_PKT_CNT_EN
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1,
`endif
  output logic                  busy,
  output logic                  grant_id
);

  sched_state_e          state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  prio_q, prio_d;   // requester that wins a tie
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic cred_nz;
  logic gnt_valid;
  logic fire;
  logic last_beat;
  logic winner;

  out_credit_counter #(
    .CREDITS    (CREDITS),
    .CRED_WIDTH (CRED_WIDTH)
  ) u_credits (
    .clk_i     (M_AXIS_ACLK),
    .rst_ni    (M_AXIS_ARESETN),
    .take_i    (fire),
    .ret_i     (credit_ret),
    .nonzero_o (cred_nz)
  );

  assign gnt_valid = grant_q ? req1_valid : req0_valid;
  assign fire      = (state_q == StStream) && gnt_valid && cred_nz;
  assign last_beat = (beat_cnt_q == len_q);
  assign winner    = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // Arbitration cycle: no beat moves here.
        if (req0_valid || req1_valid) begin
          grant_d    = winner;
          len_d      = winner ? cfg_len1 : cfg_len0;
          beat_cnt_d = '0;
          state_d    = StStream;
        end
      end
      StStream: begin
        if (fire) begin
          tdata_d    = grant_q ? req1_data : req0_data;
          tvalid_d   = 1'b1;
          tlast_d    = last_beat;
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (last_beat) begin
            state_d = StIdle;
            prio_d  = ~grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

`ifdef OUT_SCHED_PKT_CNT_EN
  logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0] pkt_cnt1_q, pkt_cnt1_d;

  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (fire && last_beat) begin
      if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
      else         pkt_cnt0_d = pkt_cnt0_q + 32'd1;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`endif

  assign req0_ready = (state_q == StStream) && !grant_q && cred_nz;
  assign req1_ready = (state_q == StStream) &&  grant_q && cred_nz;
  assign TDATA_out  = tdata_q;
  assign TVALID_out = tvalid_q;
  assign TLAST_out  = tlast_q;
  assign busy       = (state_q == StStream);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_axis_out_scheduler.sv
module tb_axis_out_scheduler;

  localparam int DW      = 32;
  localparam int LW      = 16;
  localparam int CREDITS = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [LW-1:0] len0, len1;
  logic          r0v, r1v, r0r, r1r, cr;
  logic [DW-1:0] d0, d1, tdata;
  logic          tvalid, tlast, busy, gid;
`ifdef OUT_SCHED_PKT_CNT_EN
  logic [31:0]   pc0, pc1;
`endif

  always #5 clk = ~clk;

  axis_out_scheduler dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rstn),
    .cfg_len0       (len0),
    .cfg_len1       (len1),
    .req0_valid     (r0v),
    .req0_data      (d0),
    .req0_ready     (r0r),
    .req1_valid     (r1v),
    .req1_data      (d1),
    .req1_ready     (r1r),
    .credit_ret     (cr),
    .TDATA_out      (tdata),
    .TVALID_out     (tvalid),
    .TLAST_out      (tlast),
`ifdef OUT_SCHED_PKT_CNT_EN
    .pkt_cnt0       (pc0),
    .pkt_cnt1       (pc1),
`endif
    .busy           (busy),
    .grant_id       (gid)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model, phrased as packets: who owns the output, beats still owed, last winner.
  bit            m_busy, m_owner, m_last, m_tvalid, m_tlast;
  int            m_remaining, m_credits;
  logic [DW-1:0] m_tdata;
  logic [31:0]   m_pkt0, m_pkt1;

  function automatic bit m_rdy(input bit k);
    return m_busy && (m_owner == k) && (m_credits > 0);
  endfunction

  task automatic model_step();
    bit fire;
    if (!rstn) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_remaining = 0; m_credits = CREDITS;
      m_tvalid = 0; m_tlast = 0; m_tdata = '0; m_pkt0 = '0; m_pkt1 = '0;
      return;
    end
    fire = 0; m_tvalid = 0; m_tlast = 0;
    if (!m_busy) begin
      if (r0v || r1v) begin
        m_owner     = (r0v && r1v) ? !m_last : r1v;
        m_remaining = (m_owner ? int'(len1) : int'(len0)) + 1;
        m_busy      = 1;
      end
    end else if ((m_owner ? r1v : r0v) && m_credits > 0) begin
      fire        = 1;
      m_tdata     = m_owner ? d1 : d0;
      m_tvalid    = 1;
      m_remaining = m_remaining - 1;
      m_tlast     = (m_remaining == 0);
      if (m_tlast) begin
        m_busy = 0;
        m_last = m_owner;
        if (m_owner) m_pkt1 = m_pkt1 + 1; else m_pkt0 = m_pkt0 + 1;
      end
    end
    m_credits = m_credits - int'(fire) + int'(cr);
    if (m_credits > CREDITS) m_credits = CREDITS;
  endtask

  task automatic cmp_model();
    bit ok;
    n_vec++;
    ok = (tvalid === m_tvalid) && (tlast === m_tlast) && (busy === m_busy) &&
         (gid === m_owner) && (tdata === m_tdata) && (r0r === m_rdy(0)) && (r1r === m_rdy(1));
`ifdef OUT_SCHED_PKT_CNT_EN
    ok = ok && (pc0 === m_pkt0) && (pc1 === m_pkt1);
`endif
    if (!ok) begin
      n_fail++;
      $display("FAIL model cyc %0d: got v=%b l=%b busy=%b gid=%b d=%h rdy=%b%b, want v=%b l=%b busy=%b gid=%b d=%h rdy=%b%b",
               cyc, tvalid, tlast, busy, gid, tdata, r0r, r1r,
               m_tvalid, m_tlast, m_busy, m_owner, m_tdata, m_rdy(0), m_rdy(1));
    end
  endtask

  // Inputs are stable here; advance model, clock, then sample 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    cmp_model();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic          rstn, r0v, r1v, cr;
    logic [LW-1:0] l0, l1;
    logic [DW-1:0] d0, d1;
    logic          tv, tl, bz, gid, rd0, rd1;
    logic [DW-1:0] td;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic v0, input logic v1, input logic c,
                              input int l0, input int l1, input int x0, input int x1,
                              input logic tv, input logic tl, input logic bz, input logic g,
                              input logic q0, input logic q1, input int td);
    vec_t v;
    v.rstn = rs; v.r0v = v0; v.r1v = v1; v.cr = c;
    v.l0 = LW'(l0); v.l1 = LW'(l1); v.d0 = DW'(x0); v.d1 = DW'(x1);
    v.tv = tv; v.tl = tl; v.bz = bz; v.gid = g; v.rd0 = q0; v.rd1 = q1; v.td = DW'(td);
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int beats;
    int seen;
    bit acc0, acc1;

    rstn = 0; r0v = 0; r1v = 0; cr = 0; len0 = '0; len1 = '0; d0 = '0; d1 = '0;

    //            rs v0 v1 cr l0 l1  d0     d1      tv tl bz g  r0 r1 td
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,     0,      0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 3, 0, 'h100, 0,      0, 0, 1, 0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 3, 0, 'h100, 0,      1, 0, 1, 0, 1, 0, 'h100);
    tbl[3]  = mk(1, 1, 0, 1, 3, 0, 'h101, 0,      1, 0, 1, 0, 1, 0, 'h101);
    tbl[4]  = mk(1, 1, 0, 1, 3, 0, 'h102, 0,      1, 0, 1, 0, 1, 0, 'h102);
    tbl[5]  = mk(1, 1, 0, 1, 3, 0, 'h103, 0,      1, 1, 0, 0, 0, 0, 'h103);
    tbl[6]  = mk(1, 0, 0, 1, 3, 0, 0,     0,      0, 0, 0, 0, 0, 0, 'h103);
    tbl[7]  = mk(1, 0, 1, 1, 3, 0, 0,     'h200,  0, 0, 1, 1, 0, 1, 'h103);
    tbl[8]  = mk(1, 0, 1, 1, 3, 5, 0,     'h200,  1, 1, 0, 1, 0, 0, 'h200);
    tbl[9]  = mk(1, 1, 1, 1, 1, 1, 'h300, 'h400,  0, 0, 1, 0, 1, 0, 'h200);
    tbl[10] = mk(1, 1, 1, 1, 1, 1, 'h300, 'h400,  1, 0, 1, 0, 1, 0, 'h300);
    tbl[11] = mk(1, 1, 1, 1, 1, 1, 'h301, 'h400,  1, 1, 0, 0, 0, 0, 'h301);
    tbl[12] = mk(1, 1, 1, 1, 1, 1, 'h301, 'h400,  0, 0, 1, 1, 0, 1, 'h301);
    tbl[13] = mk(1, 1, 1, 1, 1, 1, 'h301, 'h400,  1, 0, 1, 1, 0, 1, 'h400);
    tbl[14] = mk(1, 1, 1, 1, 1, 1, 'h301, 'h401,  1, 1, 0, 1, 0, 0, 'h401);
    tbl[15] = mk(1, 1, 1, 1, 1, 1, 'h302, 'h401,  0, 0, 1, 0, 1, 0, 'h401);
    tbl[16] = mk(1, 1, 1, 1, 1, 1, 'h302, 'h401,  1, 0, 1, 0, 1, 0, 'h302);
    tbl[17] = mk(1, 1, 1, 1, 1, 1, 'h303, 'h401,  1, 1, 0, 0, 0, 0, 'h303);

    for (int i = 0; i < 18; i++) begin
      rstn = tbl[i].rstn; r0v = tbl[i].r0v; r1v = tbl[i].r1v; cr = tbl[i].cr;
      len0 = tbl[i].l0; len1 = tbl[i].l1; d0 = tbl[i].d0; d1 = tbl[i].d1;
      cycle();
      n_vec++;
      if (tvalid !== tbl[i].tv || tlast !== tbl[i].tl || busy !== tbl[i].bz ||
          gid !== tbl[i].gid || r0r !== tbl[i].rd0 || r1r !== tbl[i].rd1 ||
          tdata !== tbl[i].td) begin
        n_fail++;
        $display("FAIL table[%0d]: got v=%b l=%b busy=%b gid=%b rdy=%b%b d=%h, want v=%b l=%b busy=%b gid=%b rdy=%b%b d=%h",
                 i, tvalid, tlast, busy, gid, r0r, r1r, tdata,
                 tbl[i].tv, tbl[i].tl, tbl[i].bz, tbl[i].gid, tbl[i].rd0, tbl[i].rd1, tbl[i].td);
      end
    end

    // Credit exhaustion: no returns, 8-beat packet stalls after 3 beats.
    rstn = 0; r0v = 0; r1v = 0; cr = 0; cycle();
    rstn = 1; len0 = LW'(7); r0v = 1;
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      d0 = DW'(32'hA000 + beats);
      cycle();
      if (tvalid) beats++;
    end
    chk("credit_stall_beats", beats, 3);
    chk("credit_stall_ready", r0r, 0);
    cr = 1; cycle(); cr = 0;
    beats = int'(tvalid);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (tvalid) beats++;
    end
    chk("one_return_one_beat", beats, 1);
    // Credits 0 -> 1, then fire with simultaneous return keeps 1 so next beat is not stalled.
    cr = 1; cycle();
    chk("ret_only_no_beat", tvalid, 0);
    cr = 1; cycle();
    chk("fire_ret_beat", tvalid, 1);
    cr = 0; cycle();
    chk("fire_ret_no_stall", tvalid, 1);

    // Reset mid-packet: req0 granted last, so only a reset-restored pointer picks req0 next.
    rstn = 0; r0v = 0; r1v = 0; cr = 0; cycle();
    rstn = 1; r0v = 1; len0 = LW'(0); d0 = DW'(32'hB000);
    cycle();
    len0 = LW'(4);
    cycle();
    chk("len0_one_beat_last", tlast, 1);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      d0 = DW'(32'hB100 + seen);
      cycle();
      if (tvalid) seen++;
    end
    chk("pre_reset_beats", seen, 2);
    rstn = 0; cycle();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_tdata", tdata, 0);
    rstn = 1; r0v = 1; r1v = 1; len0 = LW'(7); len1 = LW'(7); cr = 0;
    cycle();
    chk("post_rst_grant", gid, 0);
    chk("post_rst_busy", busy, 1);
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (tvalid) beats++;
    end
    chk("post_rst_credits", beats, 3);

    // Randomized traffic; a requester holds its beat until accepted.
    rstn = 0; r0v = 0; r1v = 0; cr = 0; cycle();
    rstn = 1;
    for (int i = 0; i < 3000; i++) begin
      acc0 = r0v && m_rdy(0);
      acc1 = r1v && m_rdy(1);
      if (!r0v || acc0) begin r0v = ($urandom_range(0, 3) != 0); d0 = $urandom; end
      if (!r1v || acc1) begin r1v = ($urandom_range(0, 3) != 0); d1 = $urandom; end
      len0 = LW'($urandom_range(0, 3));
      len1 = LW'($urandom_range(0, 3));
      cr   = ($urandom_range(0, 2) != 0);
      rstn = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
